// File: rtl/tcp_tx_arb_pkg.sv
// Shared types and constants for the SiTCPXG TX stream arbiter.
`timescale 1ns/1ps
package tcp_tx_arb_pkg;

    localparam int TX_WORD_W          = 64;
    localparam int TX_B_W             = 4;
    localparam int MAX_BYTES_PER_WORD = 8;
    localparam int GRANT_W            = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // A word carries 1..8 valid bytes; anything else is dropped by the arbiter.
    function automatic logic byte_cnt_ok(input logic [TX_B_W-1:0] b);
        return (b != 4'd0) && (b <= 4'(MAX_BYTES_PER_WORD));
    endfunction

    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] g, input int n_src);
        logic [GRANT_W-1:0] r_nx;
        if (int'(g) >= n_src - 1) begin
            r_nx = '0;
        end else begin
            r_nx = g + 3'd1;
        end
        return r_nx;
    endfunction

endpackage

// File: rtl/tcp_tx_rr_pick.sv
// Combinational round-robin picker: first requester at/after the pointer, wrapping.
`timescale 1ns/1ps
module tcp_tx_rr_pick
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_SRC = 2
)(
    input  logic [N_SRC-1:0]   i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [N_SRC-1:0]   o_gnt,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_any
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            for (int j = 0; j < N_SRC; j++) begin
                if ((((int'(i_ptr) + i) % N_SRC) == j) && i_req[j]) begin
                    o_any    = 1'b1;
                    o_idx    = GRANT_W'(j);
                    o_gnt    = '0;
                    o_gnt[j] = 1'b1;
                end else begin
                    o_any = o_any;
                end
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter sharing the SiTCPXG TCP TX stream between N_SRC producers.
// Optional per-source statistics outputs enabled by `TCP_TX_ARB_STATS_EN.
`timescale 1ns/1ps
module tcp_tx_arbiter
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int MAX_BURST = 64
)(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         SESSION_OPEN,
    input  logic                         TX_AFULL,
    input  logic [N_SRC-1:0]             SRC_VALID,
    input  logic [N_SRC-1:0]             SRC_LAST,
    input  logic [TX_WORD_W*N_SRC-1:0]   SRC_D,
    input  logic [TX_B_W*N_SRC-1:0]      SRC_B,
    output logic [N_SRC-1:0]             SRC_READY,
    output logic [TX_WORD_W-1:0]         TX_D,
    output logic [TX_B_W-1:0]            TX_B,
    output logic [GRANT_W-1:0]           GRANT_IDX,
    output logic                         BUSY
`ifdef TCP_TX_ARB_STATS_EN
    ,
    output logic [32*N_SRC-1:0]          STAT_BYTES,
    output logic [16*N_SRC-1:0]          STAT_PKTS
`endif
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e             r_state;
    arb_state_e             w_state_nx;
    logic [GRANT_W-1:0]     r_grant;
    logic [N_SRC-1:0]       r_gnt_oh;
    logic [GRANT_W-1:0]     r_rr;
    logic [CNT_W-1:0]       r_cnt;
    logic [TX_WORD_W-1:0]   r_tx_d;
    logic [TX_B_W-1:0]      r_tx_b;

    logic [N_SRC-1:0]       w_pick_gnt;
    logic [GRANT_W-1:0]     w_pick_idx;
    logic                   w_pick_any;
    logic                   w_ready_g;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [TX_WORD_W-1:0]   w_sel_d;
    logic [TX_B_W-1:0]      w_sel_b;
    logic                   w_accept;
    logic                   w_cnt_max;
    logic                   w_exit;

    tcp_tx_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .i_req (SRC_VALID),
        .i_ptr (r_rr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // AND-OR mux of the granted source's word.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_d     = '0;
        w_sel_b     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_sel_valid = w_sel_valid | (r_gnt_oh[i] & SRC_VALID[i]);
            w_sel_last  = w_sel_last  | (r_gnt_oh[i] & SRC_LAST[i]);
            w_sel_d     = w_sel_d | ({TX_WORD_W{r_gnt_oh[i]}} & SRC_D[TX_WORD_W*i +: TX_WORD_W]);
            w_sel_b     = w_sel_b | ({TX_B_W{r_gnt_oh[i]}} & SRC_B[TX_B_W*i +: TX_B_W]);
        end
    end

    assign w_accept  = w_ready_g & w_sel_valid;
    assign w_cnt_max = (r_cnt == CNT_W'(MAX_BURST - 1));
    assign w_exit    = w_accept & (w_sel_last | w_cnt_max);

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state logic; session loss overrides everything.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (!SESSION_OPEN) begin
                    w_state_nx = FLUSH;
                end else if (w_pick_any) begin
                    w_state_nx = BURST;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            BURST: begin
                if (!SESSION_OPEN) begin
                    w_state_nx = FLUSH;
                end else if (w_exit) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = BURST;
                end
            end
            FLUSH: begin
                if (SESSION_OPEN) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = FLUSH;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // FSM outputs: READY follows AFULL and session in the same cycle.
    always_comb begin
        w_ready_g = 1'b0;
        if (r_state == BURST) begin
            w_ready_g = SESSION_OPEN & ~TX_AFULL;
        end else begin
            w_ready_g = 1'b0;
        end
    end

    assign SRC_READY = r_gnt_oh & {N_SRC{w_ready_g}};
    assign BUSY      = (r_state == BURST);
    assign GRANT_IDX = r_grant;
    assign TX_D      = r_tx_d;
    assign TX_B      = r_tx_b;

    // Grant, round-robin pointer, burst counter and output word registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_grant  <= '0;
            r_gnt_oh <= '0;
            r_rr     <= '0;
            r_cnt    <= '0;
            r_tx_d   <= '0;
            r_tx_b   <= '0;
        end else begin
            r_tx_d <= '0;
            r_tx_b <= '0;
            if (w_accept && byte_cnt_ok(w_sel_b)) begin
                r_tx_d <= w_sel_d;
                r_tx_b <= w_sel_b;
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (SESSION_OPEN && w_pick_any) begin
                        r_grant  <= w_pick_idx;
                        r_gnt_oh <= w_pick_gnt;
                    end
                end
                BURST: begin
                    if (w_exit) begin
                        r_cnt <= '0;
                        r_rr  <= rr_next(r_grant, N_SRC);
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    r_cnt <= '0;
                    r_rr  <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef TCP_TX_ARB_STATS_EN
    logic                 r_sess_q;
    logic [32*N_SRC-1:0]  r_stat_bytes;
    logic [16*N_SRC-1:0]  r_stat_pkts;

    // Per-source counters, restarted on every new session.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sess_q     <= 1'b0;
            r_stat_bytes <= '0;
            r_stat_pkts  <= '0;
        end else begin
            r_sess_q <= SESSION_OPEN;
            if (SESSION_OPEN && !r_sess_q) begin
                r_stat_bytes <= '0;
                r_stat_pkts  <= '0;
            end else begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (w_accept && r_gnt_oh[i]) begin
                        if (byte_cnt_ok(w_sel_b)) begin
                            r_stat_bytes[32*i +: 32] <= r_stat_bytes[32*i +: 32] + {28'd0, w_sel_b};
                        end
                        if (w_sel_last) begin
                            r_stat_pkts[16*i +: 16] <= r_stat_pkts[16*i +: 16] + 16'd1;
                        end
                    end
                end
            end
        end
    end

    assign STAT_BYTES = r_stat_bytes;
    assign STAT_PKTS  = r_stat_pkts;
`endif

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: producer queues drive sources, a monitor checks TX words.
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;

    localparam int N_SRC     = 2;
    localparam int MAX_BURST = 64;

    typedef struct packed { logic [63:0] d; logic [3:0] b; logic last; } word_t;
    typedef struct packed { logic [63:0] d; logic [3:0] b; logic [2:0] src; } exp_t;

    logic               CLK = 1'b0;
    logic               RST;
    logic               SESSION_OPEN;
    logic               TX_AFULL;
    logic [N_SRC-1:0]   SRC_VALID;
    logic [N_SRC-1:0]   SRC_LAST;
    logic [64*N_SRC-1:0] SRC_D;
    logic [4*N_SRC-1:0] SRC_B;
    logic [N_SRC-1:0]   SRC_READY;
    logic [63:0]        TX_D;
    logic [3:0]         TX_B;
    logic [2:0]         GRANT_IDX;
    logic               BUSY;
`ifdef TCP_TX_ARB_STATS_EN
    logic [32*N_SRC-1:0] STAT_BYTES;
    logic [16*N_SRC-1:0] STAT_PKTS;
`endif

    word_t q0[$];
    word_t q1[$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    pop_cnt[2];

    tcp_tx_arbiter #(.N_SRC(N_SRC), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST), .SESSION_OPEN(SESSION_OPEN), .TX_AFULL(TX_AFULL),
        .SRC_VALID(SRC_VALID), .SRC_LAST(SRC_LAST), .SRC_D(SRC_D), .SRC_B(SRC_B),
        .SRC_READY(SRC_READY), .TX_D(TX_D), .TX_B(TX_B), .GRANT_IDX(GRANT_IDX), .BUSY(BUSY)
`ifdef TCP_TX_ARB_STATS_EN
        , .STAT_BYTES(STAT_BYTES), .STAT_PKTS(STAT_PKTS)
`endif
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [63:0] mk_d(input int s, input int tag, input int i);
        return {8'hA5, 8'(s), 16'(tag), 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int s, input logic [63:0] d, input logic [3:0] b, input logic last);
        word_t w;
        w.d = d; w.b = b; w.last = last;
        if (s == 0) q0.push_back(w); else q1.push_back(w);
    endtask

    task automatic load(input int s, input int tag, input int n, input int last_b, input bit has_last);
        for (int i = 0; i < n; i++)
            push_word(s, mk_d(s, tag, i), (i == n - 1) ? 4'(last_b) : 4'd8, has_last && (i == n - 1));
    endtask

    task automatic expect_rng(input int s, input int tag, input int i0, input int i1, input int n, input int last_b);
        exp_t e;
        for (int i = i0; i <= i1; i++) begin
            e.d = mk_d(s, tag, i);
            e.b = (i == n - 1) ? 4'(last_b) : 4'd8;
            e.src = 3'(s);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_heads();
        SRC_VALID = '0; SRC_LAST = '0; SRC_D = '0; SRC_B = '0;
        if (q0.size() > 0) begin
            SRC_VALID[0] = 1'b1; SRC_LAST[0] = q0[0].last; SRC_D[63:0] = q0[0].d; SRC_B[3:0] = q0[0].b;
        end
        if (q1.size() > 0) begin
            SRC_VALID[1] = 1'b1; SRC_LAST[1] = q1[0].last; SRC_D[127:64] = q1[0].d; SRC_B[7:4] = q1[0].b;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge CLK); #2;
            n++;
        end
        chk({name, "_pending"}, 64'(q0.size() + q1.size() + exp_q.size()), 64'd0);
    endtask

    // Producer driver: handshake sampled mid-cycle, queue advanced on the edge.
    initial begin
        logic [1:0] hs;
        pop_cnt[0] = 0; pop_cnt[1] = 0;
        drive_heads();
        forever begin
            @(negedge CLK);
            hs = SRC_VALID & SRC_READY;
            @(posedge CLK);
            if (hs[0] && q0.size() > 0) begin void'(q0.pop_front()); pop_cnt[0]++; end
            if (hs[1] && q1.size() > 0) begin void'(q1.pop_front()); pop_cnt[1]++; end
            #1 drive_heads();
        end
    end

    // Output monitor: every non-empty TX word must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && TX_B !== 4'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got D=%h B=%0d G=%0d expected no output", TX_D, TX_B, GRANT_IDX);
                end else begin
                    e = exp_q.pop_front();
                    if (TX_D !== e.d || TX_B !== e.b || GRANT_IDX !== e.src) begin
                        failures++;
                        $display("FAIL sb_word: got D=%h B=%0d G=%0d expected D=%h B=%0d G=%0d",
                                 TX_D, TX_B, GRANT_IDX, e.d, e.b, e.src);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        bit hit;
        RST = 1'b1; SESSION_OPEN = 1'b0; TX_AFULL = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 64'(SRC_READY), 64'd0);
        chk("rst_tx_b", 64'(TX_B), 64'd0);
        chk("rst_tx_d", TX_D, 64'd0);
        chk("rst_grant", 64'(GRANT_IDX), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        wait_cycles(1);

        // Two sources, 3-word packets: src0, src1, src0.
        load(0, 1, 3, 5, 1'b1); load(1, 2, 3, 3, 1'b1); load(0, 3, 3, 6, 1'b1);
        expect_rng(0, 1, 0, 2, 3, 5); expect_rng(1, 2, 0, 2, 3, 3); expect_rng(0, 3, 0, 2, 3, 6);
        wait_cycles(2);
        SESSION_OPEN = 1'b1;
        wait_drain(100, "t2");

        // MAX_BURST: src0 long stream is cut after 64 words, src1 slips in.
        SESSION_OPEN = 1'b0;
        wait_cycles(2);
        load(0, 4, 100, 8, 1'b1); load(1, 5, 2, 2, 1'b1);
        expect_rng(0, 4, 0, 63, 100, 8); expect_rng(1, 5, 0, 1, 2, 2); expect_rng(0, 4, 64, 99, 100, 8);
        SESSION_OPEN = 1'b1;
        wait_drain(400, "t3");

        // AFULL for 5 cycles mid-burst; words with byte count 9 and 0 are dropped.
        for (int i = 0; i < 12; i++) begin
            push_word(0, mk_d(0, 6, i), (i == 3) ? 4'd9 : (i == 4) ? 4'd0 : (i == 11) ? 4'd7 : 4'd8, i == 11);
            if (i != 3 && i != 4) expect_rng(0, 6, i, i, 12, 7);
        end
        wait_cycles(6);
        TX_AFULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t4_afull_ready", 64'(SRC_READY), 64'd0);
            if (i > 0) chk("t4_afull_tx_b", 64'(TX_B), 64'd0);
            @(posedge CLK); #2;
        end
        TX_AFULL = 1'b0;
        wait_drain(100, "t4");

        // Session loss after 10 words of src1, then reopen with both sources pending.
        load(1, 7, 30, 8, 1'b0);
        expect_rng(1, 7, 0, 9, 30, 8);
        base = pop_cnt[1];
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge CLK); #2;
            if (pop_cnt[1] - base >= 10) hit = 1'b1;
        end
        chk("t5_ten_words", 64'(hit), 64'd1);
        SESSION_OPEN = 1'b0;
        @(negedge CLK);
        chk("t5_ready_drop", 64'(SRC_READY), 64'd0);
        @(posedge CLK); #2;
        @(negedge CLK);
        chk("t5_tx_b_flush", 64'(TX_B), 64'd0);
        chk("t5_busy_flush", 64'(BUSY), 64'd0);
        q1.delete();
        load(1, 9, 2, 2, 1'b1); load(0, 8, 2, 1, 1'b1);
        expect_rng(0, 8, 0, 1, 2, 1); expect_rng(1, 9, 0, 1, 2, 2);
        wait_cycles(2);
        SESSION_OPEN = 1'b1;
        wait_drain(100, "t5");

        // Statistics: two 20-byte packets from src1 in a fresh session.
        SESSION_OPEN = 1'b0;
        wait_cycles(2);
        load(1, 10, 3, 4, 1'b1); load(1, 11, 3, 4, 1'b1);
        expect_rng(1, 10, 0, 2, 3, 4); expect_rng(1, 11, 0, 2, 3, 4);
        SESSION_OPEN = 1'b1;
        wait_drain(100, "t6");
`ifdef TCP_TX_ARB_STATS_EN
        chk("t6_bytes1", 64'(STAT_BYTES[63:32]), 64'd40);
        chk("t6_pkts1", 64'(STAT_PKTS[31:16]), 64'd2);
        chk("t6_bytes0", 64'(STAT_BYTES[31:0]), 64'd0);
        chk("t6_pkts0", 64'(STAT_PKTS[15:0]), 64'd0);
`endif

        // Asynchronous reset in the middle of a src1 burst.
        load(1, 12, 20, 8, 1'b1);
        expect_rng(1, 12, 0, 19, 20, 8);
        base = pop_cnt[1];
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge CLK); #2;
            if (pop_cnt[1] - base >= 5) hit = 1'b1;
        end
        chk("t1_busy_pre", 64'(BUSY), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("t1_rst_ready", 64'(SRC_READY), 64'd0);
        chk("t1_rst_tx_b", 64'(TX_B), 64'd0);
        chk("t1_rst_tx_d", TX_D, 64'd0);
        chk("t1_rst_grant", 64'(GRANT_IDX), 64'd0);
        chk("t1_rst_busy", 64'(BUSY), 64'd0);
        q0.delete(); q1.delete(); exp_q.delete();
        @(posedge CLK); #2 RST = 1'b0;
        @(negedge CLK);
        chk("t1_idle_after", 64'(BUSY), 64'd0);
        wait_cycles(3);
        chk("t1_idle_later", 64'(BUSY), 64'd0);
        chk("t1_tx_b_later", 64'(TX_B), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
